pipe_fixed_point_mac: RTL and testbench
=======================================

// Module: pipe_fixed_point_mac
// PURPOSE
//  Streaming fixed-point multiply-accumulate stage, downstream of the signed fixed-point multiplier.
//  Takes a frame of (ina, inb) beats over a valid/ready handshake, sums the signed products in a
//  guarded accumulator, and emits one rescaled WOI.WOF result per frame (frame ends on i_last).
//  Used for dot products and FIR taps ahead of the output formatting stages.
// PARAMETERS
//  WIIA  8  integer bits of ina (sign included)     |  WIFA  8  fraction bits of ina
//  WIIB  8  integer bits of inb (sign included)     |  WIFB  8  fraction bits of inb
//  WOI   8  integer bits of out                     |  WOF   8  fraction bits of out
//  WG    4  accumulator guard bits above the product integer width
//  ROOF  1  1: saturate out on overflow; 0: wrap (drop high bits)
//  ROUND 1  1: round to nearest, ties toward +inf; 0: floor (truncate toward -inf)
//  WCNT  16 width of o_cnt (used only with FIXED_POINT_MAC_COUNT_EN)
// PORTS
//  clk       in   1           clock, all state on rising edge
//  rst       in   1           asynchronous reset, active-high
//  i_en      in   1           input beat valid
//  i_ready   out  1           stage can accept a beat
//  i_last    in   1           beat is the last of the frame
//  ina       in   WIIA+WIFA   signed fixed-point operand A
//  inb       in   WIIB+WIFB   signed fixed-point operand B
//  o_en      out  1           result valid
//  o_ready   in   1           downstream accepts result
//  out       out  WOI+WOF     signed fixed-point frame result
//  upflow    out  1           frame result above max representable (valid with o_en)
//  downflow  out  1           frame result below min representable (valid with o_en)
// BEHAVIOUR
//  - Reset: o_en=0, out=0, upflow=0, downflow=0, acc=0, first=1; asserting rst mid-frame drops the partial sum.
//  - Widths: product WIIA+WIIB . WIFA+WIFB; accumulator WIIA+WIIB+WG . WIFA+WIFB, signed.
//  - i_ready = !o_en | o_ready; fire = i_en & i_ready.
//  - On fire: acc <= (first ? 0 : acc) + $signed(ina)*$signed(inb); first <= i_last.
//  - Accumulator add saturates at accumulator width; saturation sets sticky acc_ovf (+/- direction) for the frame.
//  - On fire with i_last: rescale the final sum (incl. this beat) to WOI.WOF, register out/flags, o_en <= 1.
//    Latency: result visible the cycle after the last-beat fire.
//  - Result held stable while o_en & !o_ready. o_en drops after o_en & o_ready unless a last-beat fire happens in the same cycle.
//  - Simultaneous o_en & o_ready & fire: handoff completes; the beat is accepted as the first term of the next frame.
//    If that beat also has i_last, out/flags load the new result and o_en stays 1.
//  - Rescale: fraction bits are reduced by ROUND. Overflow is checked on the rounded value.
//    upflow/downflow show true overflow regardless of ROOF. Sticky acc_ovf forces the matching flag and, if ROOF, the rail.
//  - Single-beat frame (i_last on first beat) is legal. i_last is ignored when fire=0.
//  - Two states: ACC (o_en=0) and HOLD (o_en=1). Transitions follow the rules above.
// CONFIGURATION
//  FIXED_POINT_MAC_COUNT_EN defined: extra output o_cnt [WCNT-1:0] = beats in the emitted frame.
//    Saturates at all-ones, registered with out, reset 0.
//  Undefined: no o_cnt port, no counter logic; all other behaviour identical.
// STRUCTURE
//  Shared package fixed_point_pkg: mac_state_t enum {ACC, HOLD}; localparam width helpers (acc/prod widths).
//  Sub-module: instance of comb_FixedPointZoom for the sum->WOI.WOF rescale (ROOF/ROUND passed through),
//  registered at its outputs; saturating accumulator add stays inline.
// TESTING (defaults, Q8.8 in/out)
//  1 beat ina=16'h0180 (1.5), inb=16'h0200 (2.0), i_last=1 -> next cycle o_en=1, out=16'h0300, flags 0.
//  3 beats 16'h0100*16'h0100, last on 3rd -> out=16'h0300. Exactly one o_en pulse with o_ready=1.
//  1 beat 16'h6400*16'h6400 (100*100) -> out=16'h7FFF, upflow=1. Same with ina=16'h9C00 (-100) -> 16'h8000, downflow=1.
//  16'h0001*16'h0080 (2^-9): ROUND=1 -> out=16'h0001; ROUND=0 -> out=16'h0000. With -2^-9: ROUND=1 -> 16'h0000.
//  Result pending with o_ready=0 for 5 cycles -> out stable, i_ready=0. Then o_ready=1 + new beat same cycle -> beat accepted as first term.
//  rst pulse after 2 of 4 beats -> o_en=0. Next 1-beat frame 1.0*1.0 -> out=16'h0100 (no stale sum).
//  With FIXED_POINT_MAC_COUNT_EN, 3-beat frame -> o_cnt=3.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared state encoding and width helpers for the fixed-point MAC
package fixed_point_pkg;
    typedef enum logic {ACC, HOLD} mac_state_t;
    function automatic int prod_width(input int wia, input int wfa, input int wib, input int wfb);
        return wia + wfa + wib + wfb;
    endfunction
    function automatic int acc_width(input int wia, input int wfa, input int wib, input int wfb, input int wg);
        return prod_width(wia, wfa, wib, wfb) + wg;
    endfunction
endpackage

// File: rtl/comb_FixedPointZoom.sv
// comb_FixedPointZoom: combinational signed WII.WIF -> WOI.WOF rescale with rounding and overflow flags
module comb_FixedPointZoom #(
    parameter int WII   = 20,
    parameter int WIF   = 16,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [WII+WIF-1:0] in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);
    localparam int WI = WII + WIF;
    localparam int WO = WOI + WOF;
    localparam int SL = WOF > WIF ? WOF - WIF : 0;
    localparam int SR = WIF > WOF ? WIF - WOF : 0;
    localparam int WB = WI + SL + WO + 2;
    localparam logic signed [WB-1:0] HALF = (ROUND != 0 && SR > 0) ? {{(WB-1){1'b0}}, 1'b1} << (SR > 0 ? SR - 1 : 0) : '0;
    localparam logic signed [WB-1:0] MAXV = {{(WB-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WB-1:0] MINV = {{(WB-WO+1){1'b1}}, {(WO-1){1'b0}}};
    logic signed [WB-1:0] ext, sc;
    assign ext      = {{(WB-WI){in[WI-1]}}, in};
    assign sc       = ((ext <<< SL) + HALF) >>> SR;
    assign upflow   = sc > MAXV;
    assign downflow = sc < MINV;
    assign out      = (ROOF != 0 && upflow)   ? {1'b0, {(WO-1){1'b1}}} :
                      (ROOF != 0 && downflow) ? {1'b1, {(WO-1){1'b0}}} : sc[WO-1:0];
endmodule

// File: rtl/pipe_fixed_point_mac.sv
// pipe_fixed_point_mac: streaming framed multiply-accumulate with rescaled WOI.WOF result (optional FIXED_POINT_MAC_COUNT_EN adds o_cnt)
module pipe_fixed_point_mac
    import fixed_point_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int WG    = 4,
    parameter int ROOF  = 1,
    parameter int ROUND = 1,
    parameter int WCNT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    output logic                 i_ready,
    input  logic                 i_last,
    input  logic [WIIA+WIFA-1:0] ina,
    input  logic [WIIB+WIFB-1:0] inb,
    output logic                 o_en,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
`ifdef FIXED_POINT_MAC_COUNT_EN
    output logic [WCNT-1:0]      o_cnt,
`endif
    output logic                 downflow
);
    localparam int WP = prod_width(WIIA, WIFA, WIIB, WIFB);
    localparam int WA = acc_width(WIIA, WIFA, WIIB, WIFB, WG);
    localparam int WO = WOI + WOF;
    mac_state_t state, state_nxt;
    logic fire, last_fire, first, pos, neg, ovf_p, ovf_n, ovf_p_nxt, ovf_n_nxt, z_up, z_dn;
    logic signed [WP-1:0] prod;
    logic signed [WA-1:0] acc, base, acc_nxt;
    logic [WA:0] sum;
    logic [WO-1:0] z_out;
    assign o_en      = state == HOLD;
    assign i_ready   = !o_en | o_ready;
    assign fire      = i_en & i_ready;
    assign last_fire = fire & i_last;
    assign prod      = $signed(ina) * $signed(inb);
    assign base      = first ? '0 : acc;
    assign sum       = {base[WA-1], base} + {{(WA+1-WP){prod[WP-1]}}, prod};
    assign pos       = !sum[WA] & sum[WA-1];
    assign neg       = sum[WA] & !sum[WA-1];
    assign acc_nxt   = pos ? {1'b0, {(WA-1){1'b1}}} : neg ? {1'b1, {(WA-1){1'b0}}} : sum[WA-1:0];
    assign ovf_p_nxt = (!first & ovf_p) | pos;
    assign ovf_n_nxt = (!first & ovf_n) | neg;

    comb_FixedPointZoom #(
        .WII(WIIA + WIIB + WG), .WIF(WIFA + WIFB), .WOI(WOI), .WOF(WOF), .ROOF(ROOF), .ROUND(ROUND)
    ) u_zoom (
        .in(acc_nxt), .out(z_out), .upflow(z_up), .downflow(z_dn)
    );

    // accumulate each accepted beat; the first beat of a frame restarts the sum and overflow history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            first <= 1'b1;
            ovf_p <= 1'b0;
            ovf_n <= 1'b0;
        end else if (fire) begin
            acc   <= acc_nxt;
            first <= i_last;
            ovf_p <= ovf_p_nxt;
            ovf_n <= ovf_n_nxt;
        end
    end

    // capture the rescaled frame result; accumulator saturation forces the flag and, when saturating, the rail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else if (last_fire) begin
            out      <= (ROOF != 0 && ovf_p_nxt) ? {1'b0, {(WO-1){1'b1}}} :
                        (ROOF != 0 && ovf_n_nxt) ? {1'b1, {(WO-1){1'b0}}} : z_out;
            upflow   <= z_up | ovf_p_nxt;
            downflow <= z_dn | ovf_n_nxt;
        end
    end

`ifdef FIXED_POINT_MAC_COUNT_EN
    logic [WCNT-1:0] bcnt, cbase, bcnt_nxt;
    assign cbase    = first ? '0 : bcnt;
    assign bcnt_nxt = &cbase ? cbase : cbase + WCNT'(1);
    // saturating beat counter, published alongside the frame result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            o_cnt <= '0;
        end else if (fire) begin
            bcnt  <= bcnt_nxt;
            o_cnt <= last_fire ? bcnt_nxt : o_cnt;
        end
    end
`endif

    // state register: ACC while collecting, HOLD while a result waits for downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // a last-beat fire always (re)enters HOLD; otherwise a completed handoff returns to ACC
    always_comb begin
        state_nxt = state;
        state_nxt = last_fire ? HOLD : (state == HOLD && o_ready) ? ACC : state;
    end
endmodule

// File: tb/tb_pipe_fixed_point_mac.sv
// tb_pipe_fixed_point_mac: directed vectors against a rounding/saturating and a floor/wrapping instance
module tb_pipe_fixed_point_mac;
    logic clk = 0, rst = 1, i_en = 0, i_last = 0, o_ready = 1;
    logic [15:0] ina = '0, inb = '0;
    logic i_ready, o_en, upflow, downflow;
    logic i_ready_f, o_en_f, upflow_f, downflow_f;
    logic [15:0] out, out_f;
`ifdef FIXED_POINT_MAC_COUNT_EN
    logic [15:0] o_cnt, o_cnt_f;
`endif
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    pipe_fixed_point_mac dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_ready(i_ready), .i_last(i_last), .ina(ina), .inb(inb),
        .o_en(o_en), .o_ready(o_ready), .out(out), .upflow(upflow),
`ifdef FIXED_POINT_MAC_COUNT_EN
        .o_cnt(o_cnt),
`endif
        .downflow(downflow)
    );

    pipe_fixed_point_mac #(.ROOF(0), .ROUND(0)) dut_f (
        .clk(clk), .rst(rst), .i_en(i_en), .i_ready(i_ready_f), .i_last(i_last), .ina(ina), .inb(inb),
        .o_en(o_en_f), .o_ready(o_ready), .out(out_f), .upflow(upflow_f),
`ifdef FIXED_POINT_MAC_COUNT_EN
        .o_cnt(o_cnt_f),
`endif
        .downflow(downflow_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive one beat for one clock; returns on the negedge after the accepting edge
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        @(negedge clk);
        i_en = 1; ina = a; inb = b; i_last = last;
        @(negedge clk);
        i_en = 0; i_last = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_o_en", o_en, 0);
        check("rst_out", out, 0);
        check("rst_flags", {upflow, downflow}, 0);
        check("rst_i_ready", i_ready, 1);
        rst = 0;

        beat(16'h0180, 16'h0200, 1);
        check("one_o_en", o_en, 1);
        check("one_out", out, 16'h0300);
        check("one_flags", {upflow, downflow}, 0);
`ifdef FIXED_POINT_MAC_COUNT_EN
        check("one_cnt", o_cnt, 1);
`endif

        beat(16'h0100, 16'h0100, 0);
        check("three_idle1", o_en, 0);
        beat(16'h0100, 16'h0100, 0);
        check("three_idle2", o_en, 0);
        beat(16'h0100, 16'h0100, 1);
        check("three_o_en", o_en, 1);
        check("three_out", out, 16'h0300);
`ifdef FIXED_POINT_MAC_COUNT_EN
        check("three_cnt", o_cnt, 3);
`endif
        @(negedge clk);
        check("three_single_pulse", o_en, 0);

        beat(16'h6400, 16'h6400, 1);
        check("pos_sat_out", out, 16'h7FFF);
        check("pos_sat_flags", {upflow, downflow}, 2'b10);
        check("pos_wrap_out", out_f, 16'h1000);
        check("pos_wrap_flags", {upflow_f, downflow_f}, 2'b10);
        beat(16'h9C00, 16'h6400, 1);
        check("neg_sat_out", out, 16'h8000);
        check("neg_sat_flags", {upflow, downflow}, 2'b01);
        check("neg_wrap_out", out_f, 16'hF000);
        check("neg_wrap_flags", {upflow_f, downflow_f}, 2'b01);

        beat(16'h0001, 16'h0080, 1);
        check("rnd_half_up", out, 16'h0001);
        check("floor_half", out_f, 16'h0000);
        beat(16'hFFFF, 16'h0080, 1);
        check("rnd_neg_half", out, 16'h0000);
        check("floor_neg_half", out_f, 16'hFFFF);

        @(negedge clk);
        o_ready = 0;
        beat(16'h0100, 16'h0300, 1);
        check("hold_out0", out, 16'h0300);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out", out, 16'h0300);
            check("hold_o_en", o_en, 1);
            check("hold_i_ready", i_ready, 0);
        end
        o_ready = 1; i_en = 1; ina = 16'h0200; inb = 16'h0100; i_last = 1;
        @(negedge clk);
        i_en = 0; i_last = 0;
        check("handoff_last_o_en", o_en, 1);
        check("handoff_last_out", out, 16'h0200);
        @(negedge clk);
        check("handoff_last_drop", o_en, 0);

        o_ready = 0;
        beat(16'h0100, 16'h0500, 1);
        check("handoff2_pend", out, 16'h0500);
        @(negedge clk);
        o_ready = 1; i_en = 1; ina = 16'h0100; inb = 16'h0100; i_last = 0;
        @(negedge clk);
        i_en = 0;
        check("handoff_first_drop", o_en, 0);
        beat(16'h0100, 16'h0100, 1);
        check("handoff_first_sum", out, 16'h0200);

        beat(16'h0100, 16'h0100, 0);
        beat(16'h0100, 16'h0100, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_o_en", o_en, 0);
        check("midrst_out", out, 0);
        rst = 0;
        beat(16'h0100, 16'h0100, 1);
        check("midrst_fresh", out, 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
